wb_timeout_reg: RTL and testbench

- Registered Wishbone classic-cycle stage placed directly downstream of the 3-port Wishbone arbiter's slave port, in front of the shared slave.
- Breaks the combinational arbiter-to-slave timing path.
- Enforces a bus watchdog: if the slave gives no ack/err/rty within TIMEOUT cycles, it terminates the master transfer with err and reports the faulting address.

---
 rtl/wb_pkg.sv | 29 ++
 rtl/wb_timeout_reg.sv | 179 +++++++++++++++++
 tb/tb_wb_timeout_reg.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: FSM state encoding and slave termination codes.
package wb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t REQ  = 2'd1;
    localparam state_t RESP = 2'd2;

    typedef logic [1:0] term_t;

    localparam term_t TERM_NONE = 2'd0;
    localparam term_t TERM_ACK  = 2'd1;
    localparam term_t TERM_ERR  = 2'd2;
    localparam term_t TERM_RTY  = 2'd3;

    // Collapse slave terminations to one code, ack > err > rty.
    function automatic term_t term_pick(input logic ack, input logic err, input logic rty);
        if (ack) begin
            return TERM_ACK;
        end else if (err) begin
            return TERM_ERR;
        end else if (rty) begin
            return TERM_RTY;
        end
        return TERM_NONE;
    endfunction

endpackage

// File: rtl/wb_timeout_reg.sv
// Registered Wishbone classic stage between arbiter and shared slave, with a
// watchdog that forces err and records the address when the slave stalls.
module wb_timeout_reg
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT      = 256,
    parameter int unsigned CNT_WIDTH    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic                    wbm_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
    input  logic                    wbm_stb_i,
    input  logic                    wbm_cyc_i,
    output logic                    wbm_ack_o,
    output logic                    wbm_err_o,
    output logic                    wbm_rty_o,
    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    output logic                    wbs_cyc_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i,
    input  logic                    wbs_rty_i,
    output logic                    timeout_o,
    output logic [ADDR_WIDTH-1:0]   timeout_adr_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
    localparam bit                   WDOG_EN  = (TIMEOUT != 0);

    state_t                  state;
    state_t                  state_nx;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [CNT_WIDTH-1:0]    cnt_d;
    logic                    req_act;
    logic                    req_act_d;
    logic [ADDR_WIDTH-1:0]   wbs_adr_d;
    logic [DATA_WIDTH-1:0]   wbs_dat_d;
    logic                    wbs_we_d;
    logic [SELECT_WIDTH-1:0] wbs_sel_d;
    logic [DATA_WIDTH-1:0]   wbm_dat_d;
    logic                    wbm_ack_d;
    logic                    wbm_err_d;
    logic                    wbm_rty_d;
    logic                    timeout_d;
    logic [ADDR_WIDTH-1:0]   timeout_adr_d;

    logic                    launch;
    logic                    abort;
    logic                    slv_term;
    logic                    expire;
    term_t                   slv_code;

    assign launch   = wbm_cyc_i & wbm_stb_i;
    assign abort    = ~wbm_cyc_i;
    assign slv_term = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign expire   = WDOG_EN && (cnt == CNT_LAST);
    assign slv_code = term_pick(wbs_ack_i, wbs_err_i, wbs_rty_i);

    // cyc and stb always travel together per transfer
    assign wbs_cyc_o = req_act;
    assign wbs_stb_o = req_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Master abort outranks slave termination, which outranks watchdog expiry.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (launch) state_nx = REQ;
            REQ: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (slv_term || expire) begin
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cnt_d         = cnt;
        req_act_d     = req_act;
        wbs_adr_d     = wbs_adr_o;
        wbs_dat_d     = wbs_dat_o;
        wbs_we_d      = wbs_we_o;
        wbs_sel_d     = wbs_sel_o;
        wbm_dat_d     = wbm_dat_o;
        wbm_ack_d     = 1'b0;
        wbm_err_d     = 1'b0;
        wbm_rty_d     = 1'b0;
        timeout_d     = 1'b0;
        timeout_adr_d = timeout_adr_o;
        case (state)
            IDLE: begin
                if (launch) begin
                    wbs_adr_d = wbm_adr_i;
                    wbs_dat_d = wbm_dat_i;
                    wbs_we_d  = wbm_we_i;
                    wbs_sel_d = wbm_sel_i;
                    req_act_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            REQ: begin
                if (abort) begin
                    req_act_d = 1'b0;
                end else if (slv_term) begin
                    req_act_d = 1'b0;
                    wbm_dat_d = wbs_dat_i;
                    case (slv_code)
                        TERM_ACK: wbm_ack_d = 1'b1;
                        TERM_ERR: wbm_err_d = 1'b1;
                        TERM_RTY: wbm_rty_d = 1'b1;
                        default:  ;
                    endcase
                end else if (expire) begin
                    req_act_d     = 1'b0;
                    wbm_err_d     = 1'b1;
                    timeout_d     = 1'b1;
                    timeout_adr_d = wbs_adr_o;
                    wbm_dat_d     = '0;
                end else begin
                    cnt_d = cnt + CNT_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            req_act       <= 1'b0;
            wbs_adr_o     <= '0;
            wbs_dat_o     <= '0;
            wbs_we_o      <= 1'b0;
            wbs_sel_o     <= '0;
            wbm_dat_o     <= '0;
            wbm_ack_o     <= 1'b0;
            wbm_err_o     <= 1'b0;
            wbm_rty_o     <= 1'b0;
            timeout_o     <= 1'b0;
            timeout_adr_o <= '0;
        end else begin
            cnt           <= cnt_d;
            req_act       <= req_act_d;
            wbs_adr_o     <= wbs_adr_d;
            wbs_dat_o     <= wbs_dat_d;
            wbs_we_o      <= wbs_we_d;
            wbs_sel_o     <= wbs_sel_d;
            wbm_dat_o     <= wbm_dat_d;
            wbm_ack_o     <= wbm_ack_d;
            wbm_err_o     <= wbm_err_d;
            wbm_rty_o     <= wbm_rty_d;
            timeout_o     <= timeout_d;
            timeout_adr_o <= timeout_adr_d;
        end
    end

endmodule

// File: tb/tb_wb_timeout_reg.sv
// Self-checking bench for wb_timeout_reg: directed cases plus random transfers
// scored against a cycle-count model of the transfer outcome.
module tb_wb_timeout_reg;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned T   = 8;
    localparam int          LIM = int'(T) + 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] wbm_adr_i = '0;
    logic [DW-1:0] wbm_dat_i = '0;
    logic [DW-1:0] wbm_dat_o;
    logic          wbm_we_i = 1'b0;
    logic [SW-1:0] wbm_sel_i = '0;
    logic          wbm_stb_i = 1'b0;
    logic          wbm_cyc_i = 1'b0;
    logic          wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [AW-1:0] wbs_adr_o;
    logic [DW-1:0] wbs_dat_o;
    logic          wbs_we_o;
    logic [SW-1:0] wbs_sel_o;
    logic          wbs_stb_o, wbs_cyc_o;
    logic [DW-1:0] wbs_dat_i = '0;
    logic          wbs_ack_i = 1'b0;
    logic          wbs_err_i = 1'b0;
    logic          wbs_rty_i = 1'b0;
    logic          timeout_o;
    logic [AW-1:0] timeout_adr_o;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_dat = '0;
    logic [AW-1:0] exp_tadr = '0;

    wb_timeout_reg #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT(T)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
        .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
        .wbm_cyc_i(wbm_cyc_i), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbm_rty_o(wbm_rty_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
        .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o), .wbs_stb_o(wbs_stb_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i),
        .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i), .timeout_o(timeout_o),
        .timeout_adr_o(timeout_adr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    // One master transfer against a slave terminating with `term` ({ack,err,rty})
    // at request cycle wait_n; the master aborts at request cycle abort_at if >= 0.
    task automatic xfer(input logic [AW-1:0] adr, input logic [DW-1:0] wdat,
                        input logic we, input logic [SW-1:0] sel, input int wait_n,
                        input logic [2:0] term, input logic [DW-1:0] rdata,
                        input int abort_at, input string name);
        int         exp_stb, exp_tcyc, stb_cnt, req_idx, r, tcyc, tpulses;
        int         tmo_pulses, tmo_cyc, field_bad;
        logic [2:0] exp_kind, kind;
        logic       exp_tmo;

        // Outcome from the protocol rules: one request cycle per counter value,
        // response one cycle after the deciding request cycle.
        if (abort_at >= 0 && abort_at <= wait_n && abort_at < int'(T)) begin
            exp_stb = abort_at + 1; exp_tcyc = -1; exp_kind = 3'b000; exp_tmo = 1'b0;
        end else if (wait_n < int'(T)) begin
            exp_stb  = wait_n + 1;
            exp_tcyc = wait_n + 2;
            exp_kind = term[2] ? 3'b100 : (term[1] ? 3'b010 : 3'b001);
            exp_tmo  = 1'b0;
            exp_dat  = rdata;
        end else begin
            exp_stb  = int'(T);
            exp_tcyc = int'(T) + 1;
            exp_kind = 3'b010;
            exp_tmo  = 1'b1;
            exp_dat  = '0;
            exp_tadr = adr;
        end

        wbm_adr_i = adr; wbm_dat_i = wdat; wbm_we_i = we; wbm_sel_i = sel;
        wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        stb_cnt = 0; req_idx = 0; tcyc = -1; tpulses = 0; kind = 3'b000;
        tmo_pulses = 0; tmo_cyc = -1; field_bad = 0;

        for (int c = 1; c <= LIM; c++) begin
            @(posedge clk);
            #1;
            if (wbs_stb_o) begin
                stb_cnt++;
                if (wbs_cyc_o !== 1'b1 || wbs_adr_o !== adr || wbs_dat_o !== wdat ||
                    wbs_we_o !== we || wbs_sel_o !== sel) field_bad++;
            end else if (wbs_cyc_o !== 1'b0) begin
                field_bad++;
            end
            if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
                tpulses++;
                if (tcyc < 0) begin
                    tcyc = c;
                    kind = {wbm_ack_o, wbm_err_o, wbm_rty_o};
                end
                wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
            end
            if (timeout_o) begin
                tmo_pulses++;
                tmo_cyc = c;
            end
            {wbs_ack_i, wbs_err_i, wbs_rty_i} = 3'b000;
            wbs_dat_i = $urandom;
            if (wbs_stb_o) begin
                r = req_idx;
                req_idx++;
                if (r == wait_n) begin
                    {wbs_ack_i, wbs_err_i, wbs_rty_i} = term;
                    wbs_dat_i = rdata;
                end
                if (r == abort_at) begin
                    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
                end
            end
        end
        {wbs_ack_i, wbs_err_i, wbs_rty_i} = 3'b000;

        chk({name, ".stb_cycles"}, 64'(stb_cnt), 64'(exp_stb));
        chk({name, ".term_cycle"}, 64'(tcyc), 64'(exp_tcyc));
        chk({name, ".term_pulses"}, 64'(tpulses), 64'((exp_tcyc < 0) ? 0 : 1));
        chk({name, ".term_kind"}, 64'(kind), 64'(exp_kind));
        chk({name, ".timeout_pulses"}, 64'(tmo_pulses), 64'(exp_tmo));
        chk({name, ".timeout_cycle"}, 64'(tmo_cyc), 64'(exp_tmo ? exp_tcyc : -1));
        chk({name, ".req_fields"}, 64'(field_bad), 64'(0));
        chk({name, ".rdata"}, 64'(wbm_dat_o), 64'(exp_dat));
        chk({name, ".timeout_adr"}, 64'(timeout_adr_o), 64'(exp_tadr));
    endtask

    // Idle bus with stray slave terminations: nothing may reach the master.
    task automatic idle(input int n, input string name);
        int spur;
        spur = 0;
        for (int c = 0; c < n; c++) begin
            {wbs_ack_i, wbs_err_i, wbs_rty_i} = 3'($urandom_range(1, 7));
            @(posedge clk);
            #1;
            if (wbm_ack_o || wbm_err_o || wbm_rty_o || timeout_o || wbs_stb_o) spur++;
        end
        {wbs_ack_i, wbs_err_i, wbs_rty_i} = 3'b000;
        @(posedge clk);
        #1;
        if (wbm_ack_o || wbm_err_o || wbm_rty_o || timeout_o || wbs_stb_o) spur++;
        chk({name, ".spurious"}, 64'(spur), 64'(0));
    endtask

    initial begin
        int         w, ab;
        logic [2:0] t3;

        #1 rst_n = 1'b0;
        #2;
        chk("reset.wbs_stb", 64'(wbs_stb_o), 64'(0));
        chk("reset.wbs_cyc", 64'(wbs_cyc_o), 64'(0));
        chk("reset.terms", 64'({wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}), 64'(0));
        chk("reset.wbm_dat", 64'(wbm_dat_o), 64'(0));
        chk("reset.timeout_adr", 64'(timeout_adr_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        xfer(32'h1000, 32'h0, 1'b0, 4'hF, 0, 3'b100, 32'hDEADBEEF, -1, "zero_wait_read");
        xfer(32'h1004, 32'h12345678, 1'b1, 4'hF, 5, 3'b100, 32'hCAFE0001, -1, "write_wait5");
        xfer(32'h2040, 32'h0, 1'b0, 4'hF, 99, 3'b100, 32'h0, -1, "timeout");
        idle(4, "late_ack");
        xfer(32'h3000, 32'h0, 1'b0, 4'h3, 7, 3'b100, 32'hA5A5A5A5, -1, "ack_at_expiry");
        xfer(32'h3010, 32'h0, 1'b0, 4'hF, 2, 3'b011, 32'h11223344, -1, "err_rty");
        xfer(32'h3020, 32'h0, 1'b0, 4'hF, 99, 3'b100, 32'h0, 2, "abort");
        xfer(32'h3030, 32'h0, 1'b0, 4'hF, 2, 3'b100, 32'h55667788, 2, "abort_vs_ack");
        idle(2, "post_abort");

        // asynchronous reset while the request is out on the slave side
        wbm_adr_i = 32'h4000; wbm_dat_i = 32'h0BADF00D; wbm_we_i = 1'b1; wbm_sel_i = 4'hF;
        wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid.pre_stb", 64'(wbs_stb_o), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.wbs_stb", 64'({wbs_stb_o, wbs_cyc_o}), 64'(0));
        chk("rst_mid.wbs_req", 64'({wbs_adr_o, wbs_we_o, wbs_sel_o}), 64'(0));
        chk("rst_mid.terms", 64'({wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}), 64'(0));
        chk("rst_mid.timeout_adr", 64'(timeout_adr_o), 64'(0));
        wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
        exp_dat = '0;
        exp_tadr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(32'h4000, 32'h0BADF00D, 1'b1, 4'hF, 1, 3'b001, 32'h600DD00D, -1, "after_reset");

        for (int i = 0; i < 40; i++) begin
            w  = int'($urandom_range(0, T + 2));
            t3 = 3'($urandom_range(1, 7));
            ab = -1;
            if ($urandom_range(0, 4) == 0) ab = int'($urandom_range(0, T - 2));
            xfer($urandom, $urandom, 1'($urandom), SW'($urandom), w, t3, $urandom, ab, "random");
            idle(int'($urandom_range(1, 3)), "random_idle");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
